// File: rtl/perf_pkg.sv
// Shared constants for the performance-event counter bank.
// Event channel indices, default sizing and the cycle-counter select alias.
package perf_pkg;
  localparam int NUM_EV_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  localparam int EV_INST  = 0;
  localparam int EV_ICREQ = 1;
  localparam int EV_ICHIT = 2;
  localparam int EV_DCREQ = 3;
  localparam int EV_DCHIT = 4;

  localparam int SEL_CYCLE = NUM_EV_DEF;
endpackage

// File: rtl/perf_counter.sv
// Single counter with sticky overflow flag.
// Wraps by default; holds at all-ones when PERF_SATURATE_EN is defined.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == '1) begin
        ovf <= 1'b1;
`ifdef PERF_SATURATE_EN
        cnt <= cnt;
`else
        cnt <= '0;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_event_counters.sv
// Performance-event counter bank: NUM_EV event counters plus a cycle counter.
// Optional saturation instead of wrap under PERF_SATURATE_EN.
module perf_event_counters
  import perf_pkg::*;
#(
  parameter int NUM_EV = NUM_EV_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SEL_W  = $clog2(NUM_EV + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_EV-1:0] event_in,
  input  logic              halt,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_EV:0]   ovf,
  output logic              frozen
);

  logic             active;
  logic [NUM_EV:0]  inc;
  logic [CNT_W-1:0] cnt [NUM_EV+1];
  logic [CNT_W-1:0] rd_mux;

  assign active = enable & ~frozen;
  // Top bit drives the cycle counter.
  assign inc = {active, event_in & {NUM_EV{active}}};

  for (genvar i = 0; i <= NUM_EV; i++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[i]),
      .clr (clear),
      .cnt (cnt[i]),
      .ovf (ovf[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen <= 1'b0;
    end else if (clear) begin
      frozen <= 1'b0;
    end else if (halt) begin
      frozen <= 1'b1;
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_EV; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_mux = cnt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters (NUM_EV=5, CNT_W=8).
// Read-back tables per scenario plus hand sequences for multi-cycle cases.
module tb_perf_event_counters;
  import perf_pkg::*;

  localparam int NUM_EV = 5;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 3;
`ifdef PERF_SATURATE_EN
  localparam logic [7:0] WRAPV = 8'd255;
`else
  localparam logic [7:0] WRAPV = 8'd0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NUM_EV-1:0] event_in;
  logic              halt;
  logic              clear;
  logic              rd_req;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_EV:0]   ovf;
  logic              frozen;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int              grp;
    logic [2:0]      sel;
    logic [7:0]      exp;
  } rd_vec_t;

  rd_vec_t tbl[$];

  perf_event_counters #(
    .NUM_EV (NUM_EV),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .event_in (event_in),
    .halt     (halt),
    .clear    (clear),
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .ovf      (ovf),
    .frozen   (frozen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] sel, input logic [7:0] exp,
                    input string name);
    rd_req = 1'b1;
    rd_sel = sel;
    step();
    rd_req = 1'b0;
    chk({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(name, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic do_reads(input int g);
    foreach (tbl[k]) begin
      if (tbl[k].grp == g) begin
        rd(tbl[k].sel, tbl[k].exp, $sformatf("g%0d_sel%0d", g, tbl[k].sel));
      end
    end
  endtask

  function automatic rd_vec_t mk(int g, int s, int e);
    rd_vec_t v;
    v.grp = g;
    v.sel = 3'(s);
    v.exp = 8'(e);
    return v;
  endfunction

  initial begin
    for (int s = 0; s <= 5; s++) tbl.push_back(mk(0, s, 0));
    tbl.push_back(mk(1, EV_INST, 11));
    tbl.push_back(mk(1, EV_ICREQ, 0));
    tbl.push_back(mk(1, EV_DCHIT, 0));
    tbl.push_back(mk(1, SEL_CYCLE, 11));
    tbl.push_back(mk(1, 6, 0));
    tbl.push_back(mk(1, 7, 0));
    tbl.push_back(mk(3, EV_ICHIT, int'(WRAPV)));
    tbl.push_back(mk(3, SEL_CYCLE, int'(WRAPV)));
    tbl.push_back(mk(3, EV_INST, 0));
    for (int s = 0; s <= 5; s++) tbl.push_back(mk(5, s, 0));
    tbl.push_back(mk(6, EV_INST, 0));
    tbl.push_back(mk(6, EV_ICREQ, 4));
    tbl.push_back(mk(6, EV_DCREQ, 4));
    tbl.push_back(mk(6, SEL_CYCLE, 4));

    rst = 1'b1; enable = 1'b0; event_in = '0; halt = 1'b0;
    clear = 1'b0; rd_req = 1'b0; rd_sel = '0;
    #3;
    chk("reset_frozen", {31'd0, frozen}, 32'd0);
    chk("reset_ovf", {26'd0, ovf}, 32'd0);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Async reset mid-count with counters at 7.
    enable = 1'b1; event_in = '1;
    repeat (7) step();
    enable = 1'b0; event_in = '0; halt = 1'b1;
    step();
    halt = 1'b0;
    rd(EV_INST, 8'd7, "pre_rst_rd");
    chk("pre_rst_frozen", {31'd0, frozen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("async_rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("async_rst_frozen", {31'd0, frozen}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    do_reads(0);

    // Halt counts its own cycle then freezes.
    enable = 1'b1; event_in = 5'b00001;
    repeat (10) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt_frozen", {31'd0, frozen}, 32'd1);
    repeat (5) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt_again_frozen", {31'd0, frozen}, 32'd1);
    chk("halt_ovf", {26'd0, ovf}, 32'd0);
    do_reads(1);

    // Read latency, back-to-back reads, out-of-range select, hold.
    clear = 1'b1; event_in = '0;
    step();
    clear = 1'b0;
    chk("clear_unfreeze", {31'd0, frozen}, 32'd0);
    repeat (20) step();
    rd(SEL_CYCLE, 8'd20, "rd_cycle20");
    rd(3'd7, 8'd0, "rd_sel7");
    rd(SEL_CYCLE, 8'd22, "rd_cycle22");
    step();
    chk("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
    chk("rd_data_hold", {24'd0, rd_data}, 32'd22);

    // Wrap / saturate on channel 2 and the cycle counter.
    clear = 1'b1; enable = 1'b0;
    step();
    clear = 1'b0; enable = 1'b1; event_in = 5'b00100;
    repeat (256) step();
    enable = 1'b0; event_in = '0;
    chk("wrap_ovf", {26'd0, ovf}, 32'h24);
    do_reads(3);

    // clear beats halt and events in the same cycle.
    enable = 1'b1; event_in = '1;
    repeat (3) step();
    clear = 1'b1; halt = 1'b1;
    step();
    clear = 1'b0; halt = 1'b0; event_in = '0; enable = 1'b0;
    chk("clr_prio_frozen", {31'd0, frozen}, 32'd0);
    chk("clr_prio_ovf", {26'd0, ovf}, 32'd0);
    do_reads(5);

    // enable low holds counts; halt still freezes.
    enable = 1'b1; event_in = 5'b01010;
    repeat (4) step();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      event_in = 5'(i * 7 + 3);
      step();
    end
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("en_low_halt_frozen", {31'd0, frozen}, 32'd1);
    enable = 1'b1; event_in = '1;
    repeat (3) step();
    do_reads(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
